// File: rtl/count_sequence_checker.sv
// -----------------------------------------------------------------------------
// count_sequence_checker
//
// Receive-side checker for a free-running 0..MAX_COUNT wrap-around counter.
// Hunts for an in-range sample, confirms LOCK_THRESH consecutive in-sequence
// samples, then flags every sample that breaks the sequence while locked.
// Lock is dropped after LOSS_THRESH consecutive bad samples.
//
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high; clears all state
//   data_in     : sampled count value (WIDTH bits)
//   valid_in    : data_in is sampled only when 1
//   locked      : registered, 1 while in LOCKED
//   error       : one-cycle pulse per bad sample taken while locked
//   wrap        : one-cycle pulse per matching MAX_COUNT sample while locked
//   expected    : value the next valid sample must equal
//   error_count : 16-bit saturating error tally
//
// Optional feature macro: CHECKER_STATS_EN
//   defined     : error_count register is built
//   not defined : error_count is tied to 0
// -----------------------------------------------------------------------------
module count_sequence_checker #(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 10,
  parameter int LOCK_THRESH = 3,
  parameter int LOSS_THRESH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             locked,
  output logic             error,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [15:0]      error_count
);

  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [GW-1:0]    LOCK_T = GW'(LOCK_THRESH);
  localparam logic [BW-1:0]    LOSS_T = BW'(LOSS_THRESH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [BW-1:0]    bad_cnt_q, bad_cnt_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic             wrap_q, wrap_d;
  logic             in_range;
  logic             match;

  // Successor in the wrap-around count sequence.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x);
    return (x == MAX_V) ? '0 : x + 1'b1;
  endfunction

  // Saturating increment for the 16-bit tally.
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign in_range = (data_in <= MAX_V);
  assign match    = (data_in == expected_q);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    error_d    = 1'b0;
    wrap_d     = 1'b0;

    if (valid_in) begin
      unique case (state_q)
        HUNT: begin
          if (in_range) begin
            expected_d = succ(data_in);
            good_cnt_d = GW'(1);
            bad_cnt_d  = '0;
            state_d    = (LOCK_THRESH == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            expected_d = succ(expected_q);
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_d >= LOCK_T) begin
              state_d   = LOCKED;
              bad_cnt_d = '0;
            end
          end else if (in_range) begin
            // Restart confirmation from this sample instead of hunting again.
            expected_d = succ(data_in);
            good_cnt_d = GW'(1);
          end else begin
            state_d    = HUNT;
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Expected advances on every sample: a single glitch must not
          // shift the reference away from the true counter phase.
          expected_d = succ(expected_q);
          if (match) begin
            bad_cnt_d = '0;
            wrap_d    = (data_in == MAX_V);
          end else begin
            error_d   = 1'b1;
            bad_cnt_d = bad_cnt_q + 1'b1;
            if (bad_cnt_d >= LOSS_T) begin
              state_d    = HUNT;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              expected_d = '0;
            end
          end
        end
        default: begin
          state_d    = HUNT;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          expected_d = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      expected_q <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef CHECKER_STATS_EN
  logic [15:0] error_count_q, error_count_d;

  always_comb begin
    error_count_d = error_count_q;
    if (error_d) begin
      error_count_d = sat_inc16(error_count_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count_q <= '0;
    end else begin
      error_count_q <= error_count_d;
    end
  end

  assign error_count = error_count_q;
`else
  assign error_count = 16'd0;
`endif

  assign locked   = locked_q;
  assign error    = error_q;
  assign wrap     = wrap_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// -----------------------------------------------------------------------------
// Testbench for count_sequence_checker: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a behavioural model.
// -----------------------------------------------------------------------------
module tb_count_sequence_checker;

  localparam int W    = 8;
  localparam int MAXC = 10;
  localparam int LT   = 3;
  localparam int LS   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic          locked;
  logic          error;
  logic          wrap;
  logic [W-1:0]  expected;
  logic [15:0]   error_count;

  count_sequence_checker #(
    .WIDTH(W), .MAX_COUNT(MAXC), .LOCK_THRESH(LT), .LOSS_THRESH(LS)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .locked(locked), .error(error), .wrap(wrap), .expected(expected),
    .error_count(error_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lk;
    int er;
    int wr;
    int ex;
    int ec;
  } resp_t;

  resp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: mode 0 = hunting, 1 = confirming, 2 = locked.
  int m_mode, m_exp, m_good, m_bad, m_cnt;

  function automatic int nxt(int x);
    return (x + 1) % (MAXC + 1);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0;
  endtask

  task automatic model_step(int v, int d);
    resp_t r;
    r.er = 0;
    r.wr = 0;
    if (v != 0) begin
      if (m_mode == 0) begin
        if (d <= MAXC) begin
          m_exp = nxt(d); m_good = 1; m_bad = 0;
          m_mode = (LT == 1) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_exp = nxt(m_exp); m_good++;
          if (m_good >= LT) begin m_mode = 2; m_bad = 0; end
        end else if (d <= MAXC) begin
          m_exp = nxt(d); m_good = 1;
        end else begin
          m_mode = 0; m_good = 0;
        end
      end else begin
        if (d == m_exp) begin
          m_bad = 0;
          r.wr = (d == MAXC) ? 1 : 0;
        end else begin
          r.er = 1;
          m_bad++;
`ifdef CHECKER_STATS_EN
          if (m_cnt < 65535) m_cnt++;
`endif
        end
        m_exp = nxt(m_exp);
        if (m_bad >= LS) begin
          m_mode = 0; m_good = 0; m_bad = 0; m_exp = 0;
        end
      end
    end
    r.lk = (m_mode == 2) ? 1 : 0;
    r.ex = m_exp;
    r.ec = m_cnt;
    sbq.push_back(r);
  endtask

  // Monitor: compares DUT outputs against the oldest prediction.
  always @(negedge clock) begin
    resp_t r;
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk("locked", int'(locked), r.lk);
      chk("error", int'(error), r.er);
      chk("wrap", int'(wrap), r.wr);
      chk("expected", int'(expected), r.ex);
      chk("error_count", int'(error_count), r.ec);
      chk("error_wrap_exclusive", int'(error & wrap), 0);
    end
  end

  task automatic step(int v, int d);
    valid_in = v[0];
    data_in  = W'(d);
    @(posedge clock);
    model_step(v, d);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_locked", int'(locked), 0);
    chk("rst_expected", int'(expected), 0);
    chk("rst_error_count", int'(error_count), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_wrap", int'(wrap), 0);
    sbq.delete();
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int gcnt;
    int r;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Lock and wrap.
    for (int i = 0; i <= MAXC; i++) step(1, i);
    step(1, 0); step(1, 1); step(1, 2);

    // Single glitch: 7 in place of 5.
    step(1, 3); step(1, 4); step(1, 7); step(1, 6); step(1, 7);

    // Loss of lock then relock.
    step(1, 200); step(1, 200);
    step(1, 3); step(1, 4); step(1, 5); step(1, 6);

    // Hunt filtering from reset.
    do_reset();
    step(1, 15); step(1, 15); step(1, 4); step(1, 5); step(1, 6);

    // Valid gaps while locked, then reset between edges.
    step(1, 7); step(1, 8);
    for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 255));
    step(1, 9); step(1, 10); step(1, 0);
    do_reset();

    // Randomized traffic.
    gcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      r = $urandom_range(0, 99);
      if (r < 10) begin
        step(0, $urandom_range(0, 255));
      end else if (r < 17) begin
        step(1, $urandom_range(0, 255));
        gcnt = nxt(gcnt);
      end else if (r == 99) begin
        gcnt = $urandom_range(0, MAXC);
        step(1, gcnt);
        gcnt = nxt(gcnt);
      end else begin
        step(1, gcnt);
        gcnt = nxt(gcnt);
      end
    end

    valid_in = 1'b0;
    @(negedge clock);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
